// File: rtl/fifo_stream_reader.sv
// Drains the show-ahead receive port of the dual-clock fifo into a registered
// valid/ready stream, releasing words in bursts gated by fill level or idle timeout.
module fifo_stream_reader #(
    parameter int WIDTH     = 8,
    parameter int LENGTH    = 16,
    parameter int THRESHOLD = 4,
    parameter int TIMEOUT   = 8,
    localparam int UW       = $clog2(LENGTH),
    localparam int WW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [UW-1:0]    fifo_used,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_acknowledge,
    output logic             stream_valid,
    input  logic             stream_ready,
    output logic [WIDTH-1:0] stream_data,
    output logic             draining
);

    typedef enum logic {IDLE, DRAIN} state_t;

    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    state_t           state_q, state_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] spare_q, spare_d;

    logic used_nz, go, push, pop;

    assign used_nz = (fifo_used != '0);
    assign go      = (fifo_used >= UW'(THRESHOLD)) ||
                     ((TIMEOUT != 0) && (wait_q == WW'(TO_LAST)) && used_nz);

    // Acknowledge depends only on registered state and fifo_used, never on stream_ready.
    assign push             = (state_q == DRAIN) && used_nz && (cnt_q != 2'd2);
    assign pop              = stream_valid && stream_ready;
    assign fifo_acknowledge = push;
    assign stream_valid     = (cnt_q != 2'd0);
    assign stream_data      = head_q;
    assign draining         = (state_q == DRAIN);

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            IDLE: begin
                if (!used_nz) begin
                    wait_d = '0;
                end else if (go) begin
                    state_d = DRAIN;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            DRAIN: begin
                wait_d = '0;
                if (!used_nz) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Skid buffer: head is the presented word, spare catches the word acknowledged
    // while head is stalled.
    always_comb begin
        cnt_d   = cnt_q;
        head_d  = head_q;
        spare_d = spare_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd0) head_d  = fifo_data;
            else               spare_d = fifo_data;
        end else if (pop && !push) begin
            cnt_d  = cnt_q - 2'd1;
            head_d = spare_q;
        end else if (push && pop) begin
            if (cnt_q == 2'd1) begin
                head_d = fifo_data;
            end else begin
                head_d  = spare_q;
                spare_d = fifo_data;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            wait_q  <= '0;
            cnt_q   <= 2'd0;
            head_q  <= '0;
            spare_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
            head_q  <= head_d;
            spare_q <= spare_d;
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomized bench for fifo_stream_reader: a queue-based FIFO/stream model checks
// ordering, occupancy, protocol stability and drain timing.
module tb_fifo_stream_reader;

    localparam int WIDTH = 8, LENGTH = 16, THRESHOLD = 4, TIMEOUT = 8;
    localparam int UW = $clog2(LENGTH);

    logic             clock = 0;
    logic             reset_n;
    logic [UW-1:0]    fifo_used;
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_acknowledge;
    logic             stream_valid;
    logic             stream_ready;
    logic [WIDTH-1:0] stream_data;
    logic             draining;

    fifo_stream_reader #(.WIDTH(WIDTH), .LENGTH(LENGTH), .THRESHOLD(THRESHOLD), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset_n(reset_n), .fifo_used(fifo_used), .fifo_data(fifo_data),
        .fifo_acknowledge(fifo_acknowledge), .stream_valid(stream_valid),
        .stream_ready(stream_ready), .stream_data(stream_data), .draining(draining)
    );

    always #5 clock = ~clock;

    int checks = 0, errors = 0;
    logic [WIDTH-1:0] fq[$];   // words sitting in the FIFO
    logic [WIDTH-1:0] oq[$];   // words acknowledged, not yet delivered
    int occ = 0, tot_in = 0, tot_out = 0;
    logic s_ack, s_vld, prev_stall;
    logic [WIDTH-1:0] prev_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive();
        fifo_used = (fq.size() > LENGTH - 1) ? UW'(LENGTH - 1) : UW'(fq.size());
        fifo_data = (fq.size() != 0) ? fq[0] : '0;
    endtask

    task automatic send(input logic [WIDTH-1:0] w);
        fq.push_back(w);
        tot_in++;
    endtask

    // One clock: observe at the falling edge, update the FIFO model after the rising edge.
    task automatic cyc();
        logic [WIDTH-1:0] e;
        @(negedge clock);
        s_ack = fifo_acknowledge;
        s_vld = stream_valid;
        if (prev_stall) begin
            chk("hold_valid", stream_valid, 1);
            chk("hold_data", stream_data, prev_data);
        end
        if (s_ack) begin
            chk("ack_used_nz", fifo_used != 0, 1);
            if (fq.size() != 0) oq.push_back(fq.pop_front());
            occ++;
        end
        if (s_vld && stream_ready) begin
            if (oq.size() == 0) chk("spurious_word", 1, 0);
            else begin
                e = oq.pop_front();
                chk("order", stream_data, e);
            end
            occ--;
            tot_out++;
        end
        if (s_ack) chk("occ_le2", occ <= 2, 1);
        prev_stall = s_vld && !stream_ready;
        prev_data  = stream_data;
        @(posedge clock);
        #1;
        drive();
    endtask

    initial begin
        int n, acks;
        reset_n = 0; stream_ready = 0; fifo_used = 0; fifo_data = 0;
        prev_stall = 0; prev_data = 0;
        #12;
        chk("rst_valid", stream_valid, 0);
        chk("rst_ack", fifo_acknowledge, 0);
        chk("rst_drain", draining, 0);
        chk("rst_data", stream_data, 0);
        @(posedge clock); #1; reset_n = 1;

        // idle with empty FIFO
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("idle_ack", s_ack, 0);
            chk("idle_valid", s_vld, 0);
            chk("idle_drain", draining, 0);
        end

        // below threshold: timeout forces the drain
        stream_ready = 1;
        send(8'hA0); send(8'hA1); send(8'hA2); drive();
        n = 0;
        while (!draining && n < 50) begin cyc(); n++; end
        chk("timeout_cycles", n, TIMEOUT);
        n = 0;
        while ((draining || oq.size() != 0) && n < 50) begin cyc(); n++; end
        chk("timeout_drained", tot_out, 3);
        chk("timeout_idle", draining, 0);

        // threshold drain at full rate
        for (int i = 0; i < 5; i++) send(WIDTH'($urandom));
        drive();
        cyc();
        chk("thr_drain_next", draining, 1);
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (i < 5) chk("burst_ack", s_ack, 1);
            if (i > 0) chk("burst_valid", s_vld, 1);
        end
        cyc();
        chk("burst_ack_end", s_ack, 0);
        for (int i = 0; i < 4; i++) cyc();
        chk("burst_all_out", tot_out, 8);
        chk("burst_idle", draining, 0);

        // backpressure: skid fills with exactly two words
        stream_ready = 0;
        for (int i = 0; i < 6; i++) send(WIDTH'($urandom));
        drive();
        acks = 0;
        for (int i = 0; i < 12; i++) begin cyc(); acks += int'(s_ack); end
        chk("bp_acks", acks, 2);
        chk("bp_ack_low", fifo_acknowledge, 0);
        chk("bp_draining", draining, 1);
        stream_ready = 1;
        n = 0;
        while ((draining || oq.size() != 0) && n < 50) begin cyc(); n++; end
        chk("bp_all_out", tot_out, tot_in);

        // random sender and random ready over 200 words
        n = 0;
        while (tot_out < tot_in + 200 - (tot_in - tot_out) && n < 6000) begin
            if (tot_in < 214 && fq.size() < LENGTH - 1 && $urandom_range(0, 2) == 0) begin
                send(WIDTH'($urandom)); drive();
            end
            stream_ready = ($urandom_range(0, 2) != 0);
            cyc();
            n++;
            if (tot_out == 214) break;
        end
        chk("rand_count", tot_out, 214);
        chk("rand_fifo_empty", fq.size(), 0);

        // asynchronous reset with a full skid buffer
        stream_ready = 0;
        for (int i = 0; i < 6; i++) send(WIDTH'($urandom));
        drive();
        n = 0;
        while (occ != 2 && n < 50) begin cyc(); n++; end
        chk("pre_rst_occ", occ, 2);
        @(negedge clock); #2;
        reset_n = 0;
        #1;
        chk("arst_valid", stream_valid, 0);
        chk("arst_ack", fifo_acknowledge, 0);
        chk("arst_drain", draining, 0);
        chk("arst_data", stream_data, 0);
        fq.delete(); oq.delete(); occ = 0; prev_stall = 0;
        drive();
        @(posedge clock); #1; reset_n = 1;
        cyc();
        chk("post_rst_valid", s_vld, 0);
        chk("post_rst_drain", draining, 0);
        // a lone word must again wait the full timeout, proving the wait counter cleared
        stream_ready = 1;
        send(8'h5C); drive();
        n = 0;
        while (!draining && n < 50) begin cyc(); n++; end
        chk("post_rst_timeout", n, TIMEOUT);
        n = 0;
        while ((draining || oq.size() != 0) && n < 50) begin cyc(); n++; end
        chk("post_rst_word", oq.size() + fq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
